// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: shares the framebuffer write port between CPU pixel stores
// and a rectangle-fill engine. CPU stores always win; the fill engine walks
// the clipped rectangle in raster order, one pixel per cycle the CPU leaves free.
module fb_fill_ctrl #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [PIX_W-1:0]  cpu_wdata_i,
    input  logic              fill_start_i,
    input  logic              fill_abort_i,
    input  logic [8:0]        fill_x0_i,
    input  logic [7:0]        fill_y0_i,
    input  logic [8:0]        fill_w_i,
    input  logic [7:0]        fill_h_i,
    input  logic [PIX_W-1:0]  fill_color_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [PIX_W-1:0]  wdata_o
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t             state;
    logic [8:0]         x0_r;
    logic [7:0]         y0_r;
    logic [8:0]         w_r;
    logic [7:0]         h_r;
    logic [PIX_W-1:0]   color_r;
    logic [9:0]         ew, eh;       // clipped width / height
    logic [9:0]         cx, cy;       // column / row counters
    logic [ADDR_W-1:0]  row_base;     // y*FB_W of the current row

    logic [9:0]         room_x, room_y, clip_w, clip_h;
    logic               empty;
    logic               fill_go, col_last, row_last;
    logic [ADDR_W-1:0]  fill_addr, row_base_init;

    // Clip math, row-base seed (y*320 = y*256 + y*64) and per-cycle fill decision
    always_comb begin
        room_x        = 10'(FB_W) - {1'b0, x0_r};
        room_y        = 10'(FB_H) - {2'b0, y0_r};
        clip_w        = ({1'b0, w_r} < room_x) ? {1'b0, w_r} : room_x;
        clip_h        = ({2'b0, h_r} < room_y) ? {2'b0, h_r} : room_y;
        empty         = ({1'b0, x0_r} >= 10'(FB_W)) || ({2'b0, y0_r} >= 10'(FB_H)) ||
                        (w_r == 9'd0) || (h_r == 8'd0);
        row_base_init = ADDR_W'({y0_r, 8'b0}) + ADDR_W'({y0_r, 6'b0});
        fill_go       = (state == RUN) && !fill_abort_i && !cpu_we_i;
        col_last      = (cx == ew - 10'd1);
        row_last      = (cy == eh - 10'd1);
        fill_addr     = row_base + ADDR_W'(x0_r) + ADDR_W'(cx);
    end

    // Registered write port: CPU store first, otherwise the fill pixel if one is due
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_o    <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
        end else if (cpu_we_i) begin
            we_o    <= 1'b1;
            addr_o  <= cpu_addr_i;
            wdata_o <= cpu_wdata_i;
        end else if (fill_go) begin
            we_o    <= 1'b1;
            addr_o  <= fill_addr;
            wdata_o <= color_r;
        end else begin
            we_o    <= 1'b0;
        end
    end

    // Fill FSM with registered busy/done; counters only advance on issued pixels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fill_busy_o <= 1'b0;
            fill_done_o <= 1'b0;
            x0_r        <= '0;
            y0_r        <= '0;
            w_r         <= '0;
            h_r         <= '0;
            color_r     <= '0;
            ew          <= '0;
            eh          <= '0;
            cx          <= '0;
            cy          <= '0;
            row_base    <= '0;
        end else begin
            fill_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start_i) begin
                        x0_r        <= fill_x0_i;
                        y0_r        <= fill_y0_i;
                        w_r         <= fill_w_i;
                        h_r         <= fill_h_i;
                        color_r     <= fill_color_i;
                        state       <= SETUP;
                        fill_busy_o <= 1'b1;
                    end
                end
                SETUP: begin
                    if (fill_abort_i) begin
                        state       <= IDLE;
                        fill_busy_o <= 1'b0;
                    end else begin
                        ew       <= clip_w;
                        eh       <= clip_h;
                        row_base <= row_base_init;
                        cx       <= '0;
                        cy       <= '0;
                        if (empty) begin
                            state       <= DONE;
                            fill_done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fill_abort_i) begin
                        state       <= IDLE;
                        fill_busy_o <= 1'b0;
                    end else if (!cpu_we_i) begin
                        if (col_last) begin
                            cx       <= '0;
                            cy       <= cy + 10'd1;
                            row_base <= row_base + ADDR_W'(FB_W);
                            if (row_last) begin
                                state       <= DONE;
                                fill_done_o <= 1'b1;
                            end
                        end else begin
                            cx <= cx + 10'd1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    fill_busy_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    fill_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Bench for fb_fill_ctrl: table of fill scenarios driven cycle by cycle,
// expected port writes queued as stimulus is applied and popped as the
// write port produces them; reset-mid-fill and CPU-in-IDLE by hand.
module tb_fb_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we_i = 1'b0;
    logic [16:0] cpu_addr_i = '0;
    logic [11:0] cpu_wdata_i = '0;
    logic        fill_start_i = 1'b0;
    logic        fill_abort_i = 1'b0;
    logic [8:0]  fill_x0_i = '0;
    logic [7:0]  fill_y0_i = '0;
    logic [8:0]  fill_w_i = '0;
    logic [7:0]  fill_h_i = '0;
    logic [11:0] fill_color_i = '0;
    logic        fill_busy_o, fill_done_o, we_o;
    logic [16:0] addr_o;
    logic [11:0] wdata_o;

    fb_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .fill_start_i(fill_start_i), .fill_abort_i(fill_abort_i),
        .fill_x0_i(fill_x0_i), .fill_y0_i(fill_y0_i),
        .fill_w_i(fill_w_i), .fill_h_i(fill_h_i), .fill_color_i(fill_color_i),
        .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
        .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, w, h, color;
        int cpu_t0, cpu_n;   // CPU stores in request cycles cpu_t0..cpu_t0+cpu_n-1
        int abort_t;         // request cycle carrying abort (0 = none)
        int sb_t;            // request cycle with a start while busy (0 = none)
        int exp_done;        // cycle of the done pulse relative to start edge (0 = none)
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int fall_cyc = 0;
    bit busy_q = 1'b0;
    bit mon_en = 1'b0;
    int sb[$];           // expected writes, packed as addr*4096+data

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Port monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (we_o) begin
                int act;
                int exp;
                act = int'(addr_o) * 4096 + int'(wdata_o);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wr_port unexpected write addr=%0d data=%03h", addr_o, wdata_o);
                end else begin
                    exp = sb.pop_front();
                    if (act != exp) begin
                        bad++;
                        $display("FAIL wr_port actual addr=%0d data=%03h expected addr=%0d data=%03h",
                                 addr_o, wdata_o, exp / 4096, exp % 4096);
                    end
                end
            end
            if (fill_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_q && !fill_busy_o) fall_cyc = cyc;
        end
        busy_q = fill_busy_o;
    end

    // Caller sits at a negedge (IDLE cycle); start is driven in that cycle.
    task automatic do_fill(input vec_t v, input string name);
        int fq[$];
        int c0, d0, t;
        bit cpu, ab;
        for (int yy = v.y0; yy < v.y0 + v.h; yy++)
            for (int xx = v.x0; xx < v.x0 + v.w; xx++)
                if (xx < 320 && yy < 240) fq.push_back((yy * 320 + xx) * 4096 + v.color);
        d0 = done_cnt;
        fill_x0_i    = 9'(v.x0);
        fill_y0_i    = 8'(v.y0);
        fill_w_i     = 9'(v.w);
        fill_h_i     = 8'(v.h);
        fill_color_i = 12'(v.color);
        fill_start_i = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        fill_start_i = 1'b0;
        @(negedge clk);
        chk({name, "_busy_setup"}, int'(fill_busy_o), 1);
        t = 1;
        ab = 1'b0;
        while ((fq.size() > 0 || t < v.cpu_t0 + v.cpu_n) && t < 2000) begin
            @(negedge clk);
            cpu = (v.cpu_n > 0) && (t >= v.cpu_t0) && (t < v.cpu_t0 + v.cpu_n);
            ab  = (t == v.abort_t);
            fill_abort_i = ab;
            cpu_we_i     = cpu;
            cpu_addr_i   = 17'(100 + t - v.cpu_t0);
            cpu_wdata_i  = 12'h0AB;
            if (t == v.sb_t) begin
                fill_x0_i = 9'd200; fill_y0_i = 8'd200; fill_w_i = 9'd7; fill_h_i = 8'd7;
                fill_color_i = 12'hAAA;
                fill_start_i = 1'b1;
            end else begin
                fill_start_i = 1'b0;
            end
            if (cpu) sb.push_back((100 + t - v.cpu_t0) * 4096 + 'h0AB);
            else if (!ab && fq.size() > 0) sb.push_back(fq.pop_front());
            t++;
            if (ab) break;
        end
        @(negedge clk);
        cpu_we_i = 1'b0;
        fill_abort_i = 1'b0;
        fill_start_i = 1'b0;
        if (ab) begin
            #1;
            chk({name, "_busy_after_abort"}, int'(fill_busy_o), 0);
            chk({name, "_sb_drain"}, sb.size(), 0);
            chk({name, "_no_done"}, done_cnt - d0, 0);
        end else begin
            repeat (4) @(negedge clk);
            #1;
            chk({name, "_sb_drain"}, sb.size(), 0);
            chk({name, "_done_count"}, done_cnt - d0, 1);
            chk({name, "_done_cycle"}, done_cyc - c0, v.exp_done);
            chk({name, "_busy_fall"}, fall_cyc - c0, v.exp_done + 1);
        end
    endtask

    vec_t tbl[12];

    initial begin
        //          x0   y0   w    h    color  cpu_t0 n abort sb done
        tbl[0]  = '{10,  20,  3,   2,   'hF00, 0, 0, 0,  0, 7};   // basic
        tbl[1]  = '{318, 239, 5,   4,   'h123, 0, 0, 0,  0, 3};   // clip corner
        tbl[2]  = '{320, 0,   5,   5,   'h777, 0, 0, 0,  0, 1};   // x0 off-screen
        tbl[3]  = '{10,  10,  0,   5,   'h777, 0, 0, 0,  0, 1};   // w=0
        tbl[4]  = '{10,  20,  3,   2,   'hF00, 2, 2, 0,  0, 9};   // CPU preempts
        tbl[5]  = '{0,   0,   320, 240, 'h00F, 0, 0, 49, 0, 0};   // abort after 48 px
        tbl[6]  = '{5,   5,   2,   2,   'h0F0, 0, 0, 0,  0, 5};   // start right after abort
        tbl[7]  = '{0,   238, 2,   5,   'h333, 0, 0, 0,  0, 5};   // bottom clip
        tbl[8]  = '{0,   0,   4,   0,   'h444, 0, 0, 0,  0, 1};   // h=0
        tbl[9]  = '{0,   240, 4,   4,   'h555, 0, 0, 0,  0, 1};   // y0 off-screen
        tbl[10] = '{0,   0,   4,   1,   'h111, 0, 0, 0,  2, 5};   // start while busy
        tbl[11] = '{0,   10,  511, 1,   'h666, 0, 0, 0,  0, 321}; // full-row width clip

        #2 rst = 1'b0;
        #1;
        chk("rst_we", int'(we_o), 0);
        chk("rst_addr", int'(addr_o), 0);
        chk("rst_wdata", int'(wdata_o), 0);
        chk("rst_busy", int'(fill_busy_o), 0);
        chk("rst_done", int'(fill_done_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // CPU store passes through while idle
        cpu_we_i = 1'b1; cpu_addr_i = 17'd555; cpu_wdata_i = 12'h5A5;
        sb.push_back(555 * 4096 + 'h5A5);
        @(negedge clk);
        cpu_we_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("idle_cpu_drain", sb.size(), 0);

        for (int i = 0; i < 12; i++) do_fill(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a large fill
        mon_en = 1'b0;
        fill_x0_i = 9'd0; fill_y0_i = 8'd0; fill_w_i = 9'd320; fill_h_i = 8'd240;
        fill_color_i = 12'hFFF;
        fill_start_i = 1'b1;
        @(posedge clk);
        #1 fill_start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_we", int'(we_o), 0);
        chk("midrst_busy", int'(fill_busy_o), 0);
        chk("midrst_done", int'(fill_done_o), 0);
        chk("midrst_addr", int'(addr_o), 0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #1 chk("post_rst_idle", int'(fill_busy_o), 0);
        mon_en = 1'b1;
        do_fill(tbl[6], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
